// File: rtl/gpu_lsq_pkg.sv
// Shared parameters and types for the LSQ issue arbiter: request record,
// arbiter FSM states and the register one-hot helper.
package gpu_lsq_pkg;

  localparam int NUM_WARPS  = 4;
  localparam int ADDR_WIDTH = 8;
  localparam int LANES      = 8;
  localparam int QUEUE_SIZE = 32;
  localparam int MAX_OUT    = 4;

  localparam int WARP_W   = $clog2(NUM_WARPS);
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 1 << REG_W;
  localparam int CRED_W   = $clog2(QUEUE_SIZE);
  localparam int OUT_W    = $clog2(MAX_OUT + 1);

  // One LSQ slot is never handed out, so the full count is depth minus one.
  localparam logic [CRED_W-1:0] MAX_CREDITS = CRED_W'(QUEUE_SIZE - 1);

  typedef logic [LANES-1:0][ADDR_WIDTH-1:0] lane_addr_t;

  typedef struct packed {
    logic              instr_bit;
    logic [WARP_W-1:0] warp_num;
    logic [REG_W-1:0]  dest_reg;
    lane_addr_t        addr;
  } lsq_req_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/lsq_issue_arbiter_rr.sv
// Combinational N-way round-robin picker; the rotating pointer lives in the
// parent so this block stays stateless.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_eligible,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any_grant
);

  int w_idx;

  // Walk the ring starting at the pointer; the first eligible index wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_idx       = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(i_rr_ptr) + i) % N;
      if (!o_any_grant && i_eligible[w_idx]) begin
        o_any_grant    = 1'b1;
        o_grant_idx    = IDX_W'(w_idx);
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsq_issue_arbiter.sv
// Shares the single LSQ write port among warps: round-robin grant, credit and
// per-warp outstanding limits, pending-load scoreboard and a drain sequence.
module lsq_issue_arbiter
  import gpu_lsq_pkg::*;
(
  input  logic                                          i_clk,
  input  logic                                          i_reset_n,
  input  logic [NUM_WARPS-1:0]                          i_req_valid,
  input  logic [NUM_WARPS-1:0]                          i_req_instr_bit,
  input  logic [NUM_WARPS-1:0][REG_W-1:0]               i_req_dest_reg,
  input  logic [NUM_WARPS-1:0][LANES-1:0][ADDR_WIDTH-1:0] i_req_addr,
  output logic [NUM_WARPS-1:0]                          o_req_ready,
  output logic                                          o_lsq_write_en,
  output logic [WARP_W-1:0]                             o_lsq_warp_num,
  output logic [REG_W-1:0]                              o_lsq_dest_reg,
  output logic [LANES-1:0][ADDR_WIDTH-1:0]              o_lsq_addr,
  output logic                                          o_lsq_instr_bit,
  input  logic                                          i_done_valid,
  input  logic [WARP_W-1:0]                             i_done_warp_num,
  input  logic [REG_W-1:0]                              i_done_dest_reg,
  input  logic                                          i_done_instr_bit,
  output logic [NUM_WARPS-1:0][NUM_REGS-1:0]            o_reg_busy,
  output logic [CRED_W-1:0]                             o_credits,
  input  logic                                          i_flush_req,
  output logic                                          o_flush_done
);

  arb_state_t                           r_state;
  arb_state_t                           w_state_next;
  logic [CRED_W-1:0]                    r_credits;
  logic [NUM_WARPS-1:0][OUT_W-1:0]      r_outstanding;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0]   r_reg_busy;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0]   w_reg_busy_next;
  logic [WARP_W-1:0]                    r_rr_ptr;
  logic                                 r_lsq_write_en;
  lsq_req_t                             r_lsq_req;
  lsq_req_t                             w_grant_req;
  logic [NUM_WARPS-1:0]                 w_eligible;
  logic [NUM_WARPS-1:0]                 w_grant;
  logic [WARP_W-1:0]                    w_grant_idx;
  logic                                 w_any_grant;
  logic                                 w_done_accept;
  logic                                 w_all_idle;
  logic [NUM_WARPS-1:0]                 w_out_inc;
  logic [NUM_WARPS-1:0]                 w_out_dec;

  // Busy check uses the registered mask, so a freed register issues next cycle.
  always_comb begin
    w_eligible = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_eligible[w] = i_req_valid[w] && (r_state == RUN) && (r_credits != '0) &&
                      (r_outstanding[w] < OUT_W'(MAX_OUT)) &&
                      !r_reg_busy[w][i_req_dest_reg[w]];
    end
  end

  rr_arbiter #(
    .N     (NUM_WARPS),
    .IDX_W (WARP_W)
  ) u_rr (
    .i_eligible  (w_eligible),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  always_comb begin
    w_grant_req           = '0;
    w_grant_req.instr_bit = i_req_instr_bit[w_grant_idx];
    w_grant_req.warp_num  = w_grant_idx;
    w_grant_req.dest_reg  = i_req_dest_reg[w_grant_idx];
    w_grant_req.addr      = i_req_addr[w_grant_idx];
  end

  assign w_done_accept = i_done_valid && (r_credits != MAX_CREDITS);
  assign w_all_idle    = (r_credits == MAX_CREDITS) && (r_outstanding == '0);

  always_comb begin
    w_out_inc = '0;
    w_out_dec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_out_inc[w] = w_any_grant && (w_grant_idx == WARP_W'(w));
      w_out_dec[w] = i_done_valid && (i_done_warp_num == WARP_W'(w)) &&
                     (r_outstanding[w] != '0);
    end
  end

  // Completion clears first so a same-cycle set on the same register wins.
  always_comb begin
    w_reg_busy_next = r_reg_busy;
    if (i_done_valid && !i_done_instr_bit) begin
      w_reg_busy_next[i_done_warp_num] = r_reg_busy[i_done_warp_num] &
                                         ~reg_onehot(i_done_dest_reg);
    end
    if (w_any_grant && !w_grant_req.instr_bit) begin
      w_reg_busy_next[w_grant_idx] = w_reg_busy_next[w_grant_idx] |
                                     reg_onehot(w_grant_req.dest_reg);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (i_flush_req) w_state_next = DRAIN;
      DRAIN:   if (w_all_idle) w_state_next = DONE;
      DONE:    w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= RUN;
      r_credits      <= MAX_CREDITS;
      r_outstanding  <= '0;
      r_reg_busy     <= '0;
      r_rr_ptr       <= '0;
      r_lsq_write_en <= 1'b0;
      r_lsq_req      <= '0;
    end else begin
      r_state        <= w_state_next;
      r_reg_busy     <= w_reg_busy_next;
      r_lsq_write_en <= w_any_grant;
      if (w_any_grant) begin
        r_lsq_req <= w_grant_req;
        r_rr_ptr  <= (w_grant_idx == WARP_W'(NUM_WARPS - 1)) ? '0 : w_grant_idx + WARP_W'(1);
      end
      case ({w_any_grant, w_done_accept})
        2'b10:   r_credits <= r_credits - CRED_W'(1);
        2'b01:   r_credits <= r_credits + CRED_W'(1);
        default: r_credits <= r_credits;
      endcase
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_out_inc[w] && !w_out_dec[w]) begin
          r_outstanding[w] <= r_outstanding[w] + OUT_W'(1);
        end else if (w_out_dec[w] && !w_out_inc[w]) begin
          r_outstanding[w] <= r_outstanding[w] - OUT_W'(1);
        end
      end
    end
  end

  assign o_req_ready     = w_grant;
  assign o_lsq_write_en  = r_lsq_write_en;
  assign o_lsq_warp_num  = r_lsq_req.warp_num;
  assign o_lsq_dest_reg  = r_lsq_req.dest_reg;
  assign o_lsq_addr      = r_lsq_req.addr;
  assign o_lsq_instr_bit = r_lsq_req.instr_bit;
  assign o_reg_busy      = r_reg_busy;
  assign o_credits       = r_credits;
  assign o_flush_done    = (r_state == DONE);

endmodule

// File: tb/tb_lsq_issue_arbiter.sv
// Directed bench for lsq_issue_arbiter: contention, hazard, per-warp limit,
// credit bookkeeping, flush/drain and mid-operation reset.
module tb_lsq_issue_arbiter;
  import gpu_lsq_pkg::*;

  logic                                            clk = 1'b0;
  logic                                            reset_n;
  logic [NUM_WARPS-1:0]                            reqValid;
  logic [NUM_WARPS-1:0]                            reqInstrBit;
  logic [NUM_WARPS-1:0][REG_W-1:0]                 reqDestReg;
  logic [NUM_WARPS-1:0][LANES-1:0][ADDR_WIDTH-1:0] reqAddr;
  logic [NUM_WARPS-1:0]                            reqReady;
  logic                                            lsqWriteEn;
  logic [WARP_W-1:0]                               lsqWarpNum;
  logic [REG_W-1:0]                                lsqDestReg;
  logic [LANES-1:0][ADDR_WIDTH-1:0]                lsqAddr;
  logic                                            lsqInstrBit;
  logic                                            doneValid;
  logic [WARP_W-1:0]                               doneWarpNum;
  logic [REG_W-1:0]                                doneDestReg;
  logic                                            doneInstrBit;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0]              regBusy;
  logic [CRED_W-1:0]                               credits;
  logic                                            flushReq;
  logic                                            flushDone;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int drainWarps [12] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 3};

  lsq_issue_arbiter dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_req_valid      (reqValid),
    .i_req_instr_bit  (reqInstrBit),
    .i_req_dest_reg   (reqDestReg),
    .i_req_addr       (reqAddr),
    .o_req_ready      (reqReady),
    .o_lsq_write_en   (lsqWriteEn),
    .o_lsq_warp_num   (lsqWarpNum),
    .o_lsq_dest_reg   (lsqDestReg),
    .o_lsq_addr       (lsqAddr),
    .o_lsq_instr_bit  (lsqInstrBit),
    .i_done_valid     (doneValid),
    .i_done_warp_num  (doneWarpNum),
    .i_done_dest_reg  (doneDestReg),
    .i_done_instr_bit (doneInstrBit),
    .o_reg_busy       (regBusy),
    .o_credits        (credits),
    .i_flush_req      (flushReq),
    .o_flush_done     (flushDone)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] addrOf(input int w);
    logic [63:0] a;
    a = '0;
    for (int l = 0; l < LANES; l++) a[l*8 +: 8] = 8'(w * 16 + l);
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int w, input logic valid, input logic store,
                               input logic [REG_W-1:0] dest);
    reqValid[w]    = valid;
    reqInstrBit[w] = store;
    reqDestReg[w]  = dest;
  endtask

  task automatic setDone(input logic valid, input int w, input logic [REG_W-1:0] dest,
                         input logic store);
    doneValid    = valid;
    doneWarpNum  = WARP_W'(w);
    doneDestReg  = dest;
    doneInstrBit = store;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    reqValid = '0; reqInstrBit = '0; reqDestReg = '0;
    for (int w = 0; w < NUM_WARPS; w++) reqAddr[w] = addrOf(w);
    flushReq = 1'b0;
    setDone(1'b0, 0, 4'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_write_en", 64'(lsqWriteEn), 64'd0);
    checkOutput("rst_credits", 64'(credits), 64'd31);
    checkOutput("rst_reg_busy", 64'(regBusy), 64'd0);
    checkOutput("rst_flush_done", 64'(flushDone), 64'd0);
    checkOutput("rst_lsq_warp", 64'(lsqWarpNum), 64'd0);

    // Contention: four loads to r1..r4, expect grants 0,1,2,3.
    reset_n = 1'b1;
    for (int w = 0; w < NUM_WARPS; w++) applyStimulus(w, 1'b1, 1'b0, REG_W'(w + 1));
    #1;
    for (int k = 0; k < NUM_WARPS; k++) begin
      checkOutput($sformatf("cont_ready_%0d", k), 64'(reqReady), 64'(1 << k));
      tick();
      checkOutput($sformatf("cont_wen_%0d", k), 64'(lsqWriteEn), 64'd1);
      checkOutput($sformatf("cont_warp_%0d", k), 64'(lsqWarpNum), 64'(k));
      checkOutput($sformatf("cont_dest_%0d", k), 64'(lsqDestReg), 64'(k + 1));
      checkOutput($sformatf("cont_addr_%0d", k), 64'(lsqAddr), addrOf(k));
    end
    checkOutput("cont_credits", 64'(credits), 64'd27);
    checkOutput("cont_busy", 64'(regBusy), 64'h0010_0008_0004_0002);
    checkOutput("cont_ready_blocked", 64'(reqReady), 64'd0);
    tick();
    checkOutput("cont_wen_idle", 64'(lsqWriteEn), 64'd0);
    reqValid = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      setDone(1'b1, k, REG_W'(k + 1), 1'b0);
      tick();
    end
    setDone(1'b0, 0, 4'd0, 1'b0);
    checkOutput("cont_credits_back", 64'(credits), 64'd31);
    checkOutput("cont_busy_clear", 64'(regBusy), 64'd0);

    // Hazard: store to a register with a pending load waits for its completion.
    applyStimulus(2, 1'b1, 1'b0, 4'd5);
    #1;
    checkOutput("haz_load_ready", 64'(reqReady), 64'b0100);
    tick();
    checkOutput("haz_busy_set", 64'(regBusy[2]), 64'h0020);
    applyStimulus(2, 1'b1, 1'b1, 4'd5);
    #1;
    checkOutput("haz_store_blocked", 64'(reqReady), 64'd0);
    setDone(1'b1, 2, 4'd5, 1'b0);
    #1;
    checkOutput("haz_done_same_cycle", 64'(reqReady), 64'd0);
    tick();
    setDone(1'b0, 0, 4'd0, 1'b0);
    #1;
    checkOutput("haz_store_ready", 64'(reqReady), 64'b0100);
    tick();
    checkOutput("haz_store_instr", 64'(lsqInstrBit), 64'd1);
    checkOutput("haz_store_warp", 64'(lsqWarpNum), 64'd2);
    checkOutput("haz_credits", 64'(credits), 64'd30);
    checkOutput("haz_store_no_busy", 64'(regBusy[2]), 64'd0);
    reqValid = '0;
    setDone(1'b1, 2, 4'd5, 1'b1);
    tick();
    setDone(1'b0, 0, 4'd0, 1'b0);

    // Per-warp limit: warp 1 stores until MAX_OUT is reached.
    applyStimulus(1, 1'b1, 1'b1, 4'd0);
    #1;
    for (int k = 0; k < MAX_OUT; k++) begin
      checkOutput($sformatf("lim_ready_%0d", k), 64'(reqReady), 64'b0010);
      tick();
    end
    checkOutput("lim_credits", 64'(credits), 64'd27);
    checkOutput("lim_stalled", 64'(reqReady), 64'd0);
    setDone(1'b1, 1, 4'd0, 1'b1);
    #1;
    checkOutput("lim_done_same_cycle", 64'(reqReady), 64'd0);
    tick();
    setDone(1'b0, 0, 4'd0, 1'b0);
    #1;
    checkOutput("lim_fifth_ready", 64'(reqReady), 64'b0010);
    tick();
    checkOutput("lim_fifth_wen", 64'(lsqWriteEn), 64'd1);
    checkOutput("lim_credits_after", 64'(credits), 64'd27);
    reqValid = '0;
    for (int k = 0; k < MAX_OUT; k++) begin
      setDone(1'b1, 1, 4'd0, 1'b1);
      tick();
    end
    setDone(1'b0, 0, 4'd0, 1'b0);

    // Saturation: all warps store until every warp holds MAX_OUT entries.
    for (int w = 0; w < NUM_WARPS; w++) applyStimulus(w, 1'b1, 1'b1, 4'd0);
    #1;
    for (int k = 0; k < NUM_WARPS * MAX_OUT; k++) begin
      checkOutput($sformatf("sat_ready_%0d", k), 64'(reqReady), 64'(1 << ((2 + k) % 4)));
      tick();
    end
    checkOutput("sat_credits", 64'(credits), 64'd15);
    checkOutput("sat_ready_none", 64'(reqReady), 64'd0);
    setDone(1'b1, 0, 4'd0, 1'b1);
    tick();
    setDone(1'b1, 1, 4'd0, 1'b1);
    #1;
    checkOutput("sat_ready_w0", 64'(reqReady), 64'b0001);
    tick();
    checkOutput("sat_grant_done_credits", 64'(credits), 64'd16);
    setDone(1'b0, 0, 4'd0, 1'b0);
    reqValid = '0;
    foreach (drainWarps[i]) begin
      setDone(1'b1, drainWarps[i], 4'd0, 1'b1);
      tick();
    end
    setDone(1'b0, 0, 4'd0, 1'b0);
    checkOutput("pre_flush_credits", 64'(credits), 64'd28);

    // Flush with three stores outstanding on warp 3.
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) applyStimulus(w, 1'b1, 1'b0, 4'd7);
    #1;
    checkOutput("drain_no_grant", 64'(reqReady), 64'd0);
    for (int k = 0; k < 3; k++) begin
      setDone(1'b1, 3, 4'd0, 1'b1);
      tick();
      checkOutput($sformatf("drain_ready_%0d", k), 64'(reqReady), 64'd0);
      checkOutput($sformatf("drain_flush_done_%0d", k), 64'(flushDone), 64'd0);
    end
    setDone(1'b0, 0, 4'd0, 1'b0);
    checkOutput("drain_credits", 64'(credits), 64'd31);
    tick();
    checkOutput("flush_done_pulse", 64'(flushDone), 64'd1);
    checkOutput("flush_done_no_grant", 64'(reqReady), 64'd0);
    tick();
    checkOutput("flush_done_low", 64'(flushDone), 64'd0);
    checkOutput("resume_rr_ptr", 64'(reqReady), 64'b0010);

    // Reset mid-operation with two loads outstanding and rr_ptr at 3.
    tick();
    tick();
    checkOutput("pre_reset_credits", 64'(credits), 64'd29);
    reqValid = '0;
    reset_n  = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("mid_rst_credits", 64'(credits), 64'd31);
    checkOutput("mid_rst_busy", 64'(regBusy), 64'd0);
    checkOutput("mid_rst_wen", 64'(lsqWriteEn), 64'd0);
    checkOutput("mid_rst_flush_done", 64'(flushDone), 64'd0);
    applyStimulus(1, 1'b1, 1'b0, 4'd7);
    applyStimulus(3, 1'b1, 1'b0, 4'd7);
    #1;
    checkOutput("mid_rst_ready", 64'(reqReady), 64'b0010);
    tick();
    checkOutput("mid_rst_issue_warp", 64'(lsqWarpNum), 64'd1);
    reqValid = '0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
